// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bank
//  Description : Bank of CHANNELS independent switch debouncers. Each channel
//                has a private four-state FSM with lockout windows after
//                every accepted edge, plus a long-press detector. Registered
//                level, press, release and long-press outputs per channel.
//  Option      : define DEBOUNCE_BANK_SYNC_EN to insert a 2-flop
//                synchronizer on every sw_in bit (adds two edges of latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank #(
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 32768,
    parameter int LONG_CYCLES = 8388608
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [CHANNELS-1:0] sw_in,
    output logic [CHANNELS-1:0] sw_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] hold_pulse,
    output logic                any_active
);

    // ------------------------------------------------------------------------
    // Timer sizing: must hold the larger of the two terminal counts plus the
    // saturation value LONG_CYCLES itself, so it never wraps.
    // ------------------------------------------------------------------------
    localparam int C_TIMER_MAX = (HOLD_CYCLES > LONG_CYCLES) ? HOLD_CYCLES : LONG_CYCLES;
    localparam int C_TIMER_W   = $clog2(C_TIMER_MAX + 1);

    localparam logic [C_TIMER_W-1:0] C_HOLD_LAST = C_TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [C_TIMER_W-1:0] C_LONG_LAST = C_TIMER_W'(LONG_CYCLES - 1);
    localparam logic [C_TIMER_W-1:0] C_LONG_SAT  = C_TIMER_W'(LONG_CYCLES);
    localparam logic [C_TIMER_W-1:0] C_TIMER_ONE = C_TIMER_W'(1);

    typedef enum logic [1:0] {
        STABLE_0 = 2'd0,
        WAIT_1   = 2'd1,
        STABLE_1 = 2'd2,
        WAIT_0   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------------
    state_t               state_q [CHANNELS];
    state_t               state_d [CHANNELS];
    logic [C_TIMER_W-1:0] timer_q [CHANNELS];
    logic [C_TIMER_W-1:0] timer_d [CHANNELS];

    logic [CHANNELS-1:0]  sw_out_q;
    logic [CHANNELS-1:0]  sw_out_d;
    logic [CHANNELS-1:0]  press_q;
    logic [CHANNELS-1:0]  press_d;
    logic [CHANNELS-1:0]  release_q;
    logic [CHANNELS-1:0]  release_d;
    logic [CHANNELS-1:0]  hold_q;
    logic [CHANNELS-1:0]  hold_d;

    // Level actually seen by the FSMs (synchronized or raw)
    logic [CHANNELS-1:0]  w_sample;

`ifdef DEBOUNCE_BANK_SYNC_EN
    // ------------------------------------------------------------------------
    // Two-flop synchronizer; both stages are cleared by reset so a switch
    // held through reset is seen as a fresh press afterwards.
    // ------------------------------------------------------------------------
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync1_d;
    logic [CHANNELS-1:0] sync2_q;
    logic [CHANNELS-1:0] sync2_d;

    // Next values of the synchronizer chain
    always_comb begin
        sync1_d = sw_in;
        sync2_d = sync1_q;
    end

    // Synchronizer registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign w_sample = sync2_q;
`else
    // Raw input drives the FSMs directly; the caller guarantees sw_in is
    // already in the clk_in domain in this build.
    assign w_sample = sw_in;
`endif

    // ------------------------------------------------------------------------
    // Next-state, timer and pulse logic for every channel. Channels share
    // nothing but the loop; each one only reads its own sample bit.
    // ------------------------------------------------------------------------
    always_comb begin
        sw_out_d  = '0;
        press_d   = '0;
        release_d = '0;
        hold_d    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];

            case (state_q[i])
                STABLE_0: begin
                    timer_d[i] = '0;
                    if (w_sample[i]) begin
                        state_d[i] = WAIT_1;
                        press_d[i] = 1'b1;
                    end
                end

                WAIT_1: begin
                    // Lockout after a press: input ignored for HOLD_CYCLES
                    if (timer_q[i] == C_HOLD_LAST) begin
                        state_d[i] = STABLE_1;
                        timer_d[i] = '0;
                    end else begin
                        timer_d[i] = timer_q[i] + C_TIMER_ONE;
                    end
                end

                STABLE_1: begin
                    // Release is checked first so it wins over the long-press
                    // threshold when both land on the same edge.
                    if (!w_sample[i]) begin
                        state_d[i]   = WAIT_0;
                        timer_d[i]   = '0;
                        release_d[i] = 1'b1;
                    end else if (timer_q[i] != C_LONG_SAT) begin
                        // Saturating at LONG_CYCLES makes the long-press
                        // event fire at most once per visit.
                        timer_d[i] = timer_q[i] + C_TIMER_ONE;
                        if (timer_q[i] == C_LONG_LAST) begin
                            hold_d[i] = 1'b1;
                        end
                    end
                end

                WAIT_0: begin
                    // Lockout after a release: input ignored for HOLD_CYCLES
                    if (timer_q[i] == C_HOLD_LAST) begin
                        state_d[i] = STABLE_0;
                        timer_d[i] = '0;
                    end else begin
                        timer_d[i] = timer_q[i] + C_TIMER_ONE;
                    end
                end

                default: begin
                    state_d[i] = STABLE_0;
                    timer_d[i] = '0;
                end
            endcase

            // Debounced level follows the state being entered, so it changes
            // on the same edge as the press/release decision.
            sw_out_d[i] = (state_d[i] == WAIT_1) || (state_d[i] == STABLE_1);
        end
    end

    // ------------------------------------------------------------------------
    // State, timer and output registers; reset aborts any activity silently.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= STABLE_0;
                timer_q[i] <= '0;
            end
            sw_out_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            hold_q    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            sw_out_q  <= sw_out_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign sw_out        = sw_out_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign hold_pulse    = hold_q;
    assign any_active    = |sw_out_q;

endmodule
`default_nettype wire

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent switch channels, legal range 1..32.
REQ-002 Parameter HOLD_CYCLES, default 32768: clk_in cycles spent in each lockout (WAIT) state, legal range >= 1.
REQ-003 Parameter LONG_CYCLES, default 8388608: clk_in cycles in STABLE_1 before a long-press event, legal range >= 1.
REQ-004 clk_in  input  1: system clock; all state changes on its rising edge.
REQ-005 rst_in  input  1: reset, asynchronous, active-high.
REQ-006 sw_in  input  CHANNELS: raw switch levels, 1 = pressed, asynchronous to clk_in.
REQ-007 sw_out  output  CHANNELS: debounced level per channel.
REQ-008 press_pulse  output  CHANNELS: one-cycle pulse per debounced press.
REQ-009 release_pulse  output  CHANNELS: one-cycle pulse per debounced release.
REQ-010 hold_pulse  output  CHANNELS: one-cycle pulse per long press.
REQ-011 any_active  output  1: OR of all sw_out bits.

Function
REQ-012 Each channel shall have a private 4-state FSM (STABLE_0, WAIT_1, STABLE_1, WAIT_0) and a private timer; channels shall not interact.
REQ-013 Sampled input s[i] is the synchronizer output (REQ-030) or sw_in[i] directly (REQ-031).
REQ-014 STABLE_0: timer held at 0; s[i]=1 at a rising edge -> WAIT_1, timer cleared.
REQ-015 WAIT_1: timer increments each cycle; s[i] ignored; at timer == HOLD_CYCLES-1 -> STABLE_1, timer cleared; WAIT_1 lasts exactly HOLD_CYCLES cycles.
REQ-016 STABLE_1: s[i]=0 -> WAIT_0, timer cleared; otherwise timer increments, saturating at LONG_CYCLES.
REQ-017 WAIT_0: timer increments; s[i] ignored; at timer == HOLD_CYCLES-1 -> STABLE_0; lasts exactly HOLD_CYCLES cycles.
REQ-018 sw_out[i] shall be registered and equal 1 exactly while state is WAIT_1 or STABLE_1.
REQ-019 sw_out[i] shall rise on the same edge that enters WAIT_1 (one edge after s[i] sampled 1) and fall on the edge that enters WAIT_0.
REQ-020 press_pulse[i] shall be registered, high only during the first cycle of WAIT_1.
REQ-021 release_pulse[i] shall be registered, high only during the first cycle of WAIT_0.
REQ-022 hold_pulse[i] shall be high for exactly one cycle, the cycle after the timer reaches LONG_CYCLES-1 in STABLE_1; at most once per STABLE_1 visit.
REQ-023 If s[i]=0 on the edge where the timer equals LONG_CYCLES-1, release shall win: WAIT_0 is entered and no hold_pulse is produced.
REQ-024 Bouncing inside a WAIT state shall produce no pulses and no sw_out change.
REQ-025 Timer width shall be clog2(max(HOLD_CYCLES, LONG_CYCLES)+1) bits; no wrap-around is permitted.
REQ-026 any_active shall be combinational from the registered sw_out.

Reset
REQ-027 rst_in high shall immediately force every channel to STABLE_0 and clear all timers, synchronizer flops and pulse registers; all outputs read 0.
REQ-028 Reset mid-WAIT or mid-STABLE_1 shall abort with no release_pulse or hold_pulse.
REQ-029 After rst_in deasserts, an input still held at 1 shall be treated as a new press.

Configuration
REQ-030 With macro DEBOUNCE_BANK_SYNC_EN defined, each sw_in bit shall pass through a 2-flop synchronizer; sampled-1 to sw_out latency is 3 edges.
REQ-031 Without DEBOUNCE_BANK_SYNC_EN, s[i] = sw_in[i] directly; latency is 1 edge; all other behaviour is identical.

Verification (CHANNELS=2, HOLD_CYCLES=4, LONG_CYCLES=10, macro undefined unless noted)
REQ-032 Reset: rst_in high with sw_in=2'b11 -> all outputs 0; rst_in released -> ch0/ch1 press_pulse 1 cycle, sw_out=2'b11 on the next edge.
REQ-033 Bounce: sw_in[0] toggles 1,0,1,0 on consecutive cycles, then holds at 1 -> exactly one press_pulse; sw_out[0] stays 1; STABLE_1 is entered 4 cycles after the press edge.
REQ-034 Long press: sw_in[1]=1 held 20 cycles -> hold_pulse[1] once, 4+10 cycles after press_pulse[1]; release -> release_pulse[1], then 4-cycle lockout.
REQ-035 Simultaneous: sw_in[0] drops on the threshold edge -> release_pulse[0], no hold_pulse[0]; ch1 toggling concurrently is unaffected.
REQ-036 Sync build: with DEBOUNCE_BANK_SYNC_EN defined, sw_in[0] rise -> sw_out[0] rises 3 edges later; a 1-cycle glitch reaches the FSM delayed by 2 edges.
REQ-037 Mid-operation reset: rst_in asserted during WAIT_0 -> outputs 0 immediately, no further pulses.
